arb4_rr_ctrl: RTL
=================

# arb4_rr_ctrl

Four-requester round-robin arbiter controller that shares one single-ported resource (e.g. a memory or functional-unit port) between four requesters. It holds a one-hot grant for a multi-cycle transaction until the owner signals completion or a hold limit forces release. A 2-bit rotating priority pointer then advances past the last owner. It sits between the requesters and the resource mux, whose select it drives via `owner`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per transaction; legal range 1..15.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  arbitration enable; gates new grants only.
- `req`  in  4  per-requester request, level-sensitive.
- `done`  in  4  per-requester completion; only `done[owner]` is honoured.
- `gnt`  out  4  one-hot grant, registered; all-zero when idle.
- `owner`  out  2  index of current grantee; holds the last grantee while idle.
- `busy`  out  1  high while in GRANT (equals `|gnt`).
- `preempt`  out  1  one-cycle pulse after a forced release.
- `ptr`  out  2  rotating priority pointer: index with highest priority at next arbitration.

## Operation
- Two states: IDLE and GRANT.
- Reset values: state IDLE, `gnt`=0000, `owner`=0, `busy`=0, `preempt`=0, `ptr`=0, hold counter 0.
- Reset takes priority over all other events, including mid-transaction; the grant drops at the next edge.
- IDLE, when `en`=1 and `|req`=1:
  - Select the first set `req` bit in search order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - Next state GRANT; `gnt` gets that bit; `owner` gets its index; hold counter cleared to 0.
- IDLE otherwise: stay in IDLE; `gnt`=0.
- GRANT, hold counter: increments once per cycle spent in GRANT; its width holds `MAX_HOLD`.
- GRANT, release conditions, evaluated each cycle, any one sufficient:
  - (a) `done[owner]`=1;
  - (b) `req[owner]`=0 (requester withdrew);
  - (c) hold counter == `MAX_HOLD`-1 (last allowed cycle).
- On release: next state IDLE, `gnt` becomes 0000, `ptr` becomes `owner`+1 mod 4 (3 wraps to 0).
- Forced release: if (c) is the only true condition, `preempt`=1 for the following cycle only. If (a) or (b) is also true, release is normal and `preempt` stays 0.
- Ignored inputs: `done` bits of non-owners have no effect; `en` has no effect in GRANT.
- `ptr` changes only on release, never on grant.

## Timing
- Grant latency: `req` seen in an IDLE cycle at edge t → `gnt` high from edge t onward, i.e. `gnt` is visible the cycle after `req` was first presented.
- Grant hold: a transaction occupies between 1 and `MAX_HOLD` cycles of `gnt`.
- Release: `done` sampled high at edge t → `gnt` low after edge t.
- Minimum idle gap: one IDLE cycle always separates consecutive grants, including back-to-back grants to the same requester. Sustained full load therefore gives each grant followed by one bubble.
- `MAX_HOLD`=1: every grant lasts exactly one cycle; `preempt` pulses unless `done`/withdrawal coincides.
- `preempt` is coincident with the first IDLE cycle after a forced release.

## Test plan
- Reset then `req`=0101, `en`=1, `done[0]` on the 3rd grant cycle:
  - `gnt`=0001 for 3 cycles, one idle cycle, `ptr`=1;
  - then `gnt`=0100 (index 2 wins over 0).
- `req`=1111 held and each owner asserts `done` on its first grant cycle: grant order 0,1,2,3,0 with an idle cycle between each; `ptr` wraps 3→0.
- `MAX_HOLD`=8, `req`=0010, `done` never asserted:
  - `gnt`=0010 exactly 8 cycles, then `preempt`=1 for 1 cycle, `ptr`=2;
  - `gnt`=0010 again after the idle cycle.
- Owner 2 drops `req[2]` mid-grant while `done`=1000: `gnt` clears next cycle; `preempt`=0; `ptr`=3.
- `en`=0 with `req`=1000 → `gnt` stays 0000. Set `en`=1 → `gnt`=1000 next cycle. Then drop `en` during GRANT → grant persists until `done[3]`.
- `reset` asserted on the 4th grant cycle → next cycle `gnt`=0000, `ptr`=0, `owner`=0, `preempt`=0, `busy`=0.

Source files
------------

// File: rtl/arb4_rr_ctrl_if.sv
// arb4_rr_ctrl_if -- handshake bundle between the four requesters and the
// round-robin arbiter controller.
//   en      : arbitration enable (gates new grants only)
//   req     : per-requester level request
//   done    : per-requester completion (only the owner's bit matters)
//   gnt     : registered one-hot grant, zero when idle
//   owner   : index of current / last grantee (resource mux select)
//   busy    : high while a grant is held
//   preempt : one-cycle pulse after a hold-limit release
//   ptr     : requester index with highest priority at next arbitration
// Modports: master = requester side, slave = arbiter side.
interface arb4_rr_ctrl_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;
  logic [1:0] ptr;

  modport master (
    output en, req, done,
    input  gnt, owner, busy, preempt, ptr
  );

  modport slave (
    input  en, req, done,
    output gnt, owner, busy, preempt, ptr
  );
endinterface

// File: rtl/arb4_rr_ctrl.sv
// arb4_rr_ctrl -- four-requester round-robin arbiter controller.
// Holds a one-hot grant for a multi-cycle transaction until the owner signals
// done, withdraws its request, or MAX_HOLD grant cycles have elapsed. The
// priority pointer then moves to the index after the last owner. One idle
// cycle always separates consecutive grants.
// Ports:
//   clock : system clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : arb4_rr_ctrl_if.slave (en/req/done in, gnt/owner/busy/preempt/ptr out)
// Parameter:
//   MAX_HOLD : maximum consecutive grant cycles per transaction (1..15)
module arb4_rr_ctrl #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  arb4_rr_ctrl_if.slave        bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          preempt_q, preempt_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [1:0]    cand;
  logic [1:0]    win_idx;
  logic          win_found;
  logic          rel_done, rel_wd, rel_lim;

  // Rotating-priority search: first set request at ptr, ptr+1, ptr+2, ptr+3.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    rel_done  = bus.done[owner_q];
    rel_wd    = ~bus.req[owner_q];
    rel_lim   = (hold_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (bus.en && win_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          owner_d = win_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        hold_d = hold_q + HW'(1);
        if (rel_done || rel_wd || rel_lim) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = owner_q + 2'd1;
          // Only a pure hold-limit release counts as a preemption.
          preempt_d = rel_lim && !rel_done && !rel_wd;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q == GRANT);
  assign bus.preempt = preempt_q;
  assign bus.ptr     = ptr_q;

endmodule
